// File: rtl/mskaes_128bits_round_ctrl.sv
// Round sequencer for the masked AES-128 datapath: load, 10 rounds of LATENCY
// cycles each, masked RCON generation, PRNG gating and ciphertext handshake.
module mskaes_128bits_round_ctrl #(
  parameter int unsigned d       = 2,
  parameter int unsigned LATENCY = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           load,
  output logic           round_en,
  output logic           last_round,
  output logic [8*d-1:0] sh_RCON,
  output logic           rnd_en,
  output logic [3:0]     round,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LATENCY - 1);
  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0] FIRST_RND = RND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RND_W-1:0] round_q, round_d;
  logic [7:0]       rcon;

  // State, cycle-in-round counter and round number
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  // Next state and control decode; all outputs depend on registered state,
  // except load, which qualifies the accepted request in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    in_ready  = 1'b0;
    load      = 1'b0;
    round_en  = 1'b0;
    rnd_en    = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
          round_d = FIRST_RND;
          cnt_d   = '0;
        end
      end
      RUN: begin
        busy   = 1'b1;
        rnd_en = 1'b1;
        if (cnt_q == LAST_CNT) begin
          round_en = 1'b1;
          cnt_d    = '0;
          if (round_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + RND_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
          round_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        round_d = '0;
      end
    endcase
  end

  assign last_round = (state_q == RUN) && (round_q == LAST_RND);
  assign round      = round_q;

  // Round constant lookup, held for the whole round
  always_comb begin
    rcon = 8'h00;
    case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1B;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Share 0 carries the constant, bit b at index d*b; other shares stay zero
  always_comb begin
    sh_RCON = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      sh_RCON[d*b] = rcon[b];
    end
  end

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
// Scoreboard bench for the masked AES round controller (LATENCY=4 and LATENCY=1).
module tb_mskaes_128bits_round_ctrl;

  typedef struct packed {
    logic ov;
    int   cyc;
    int   rnd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, load, round_en, last_round, rnd_en, out_valid, busy;
  logic [15:0] sh_RCON;
  logic [3:0]  round;

  logic        in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic        in_ready1, load1, round_en1, last_round1, rnd_en1, out_valid1, busy1;
  logic [15:0] sh_RCON1;
  logic [3:0]  round1;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q0[$];
  exp_t q1[$];

  mskaes_128bits_round_ctrl #(.d(2), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .round_en(round_en), .last_round(last_round),
    .sh_RCON(sh_RCON), .rnd_en(rnd_en), .round(round),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  mskaes_128bits_round_ctrl #(.d(2), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .load(load1), .round_en(round_en1), .last_round(last_round1),
    .sh_RCON(sh_RCON1), .rnd_en(rnd_en1), .round(round1),
    .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rc(input int k);
    case (k)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1B; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] spread(input logic [7:0] r);
    logic [15:0] s;
    s = '0;
    for (int b = 0; b < 8; b++) s[2*b] = r[b];
    return s;
  endfunction

  function automatic void push_enc(input int t, input int lat, input bit second);
    exp_t e;
    for (int k = 1; k <= 10; k++) begin
      e.ov = 1'b0; e.cyc = t + k*lat; e.rnd = k;
      if (second) q1.push_back(e); else q0.push_back(e);
    end
    e.ov = 1'b1; e.cyc = t + 1 + 10*lat; e.rnd = 10;
    if (second) q1.push_back(e); else q0.push_back(e);
  endfunction

  // Monitor for the LATENCY=4 instance
  int   n_rnd, n_re, n_lr;
  logic ov_prev;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      n_rnd = 0; n_re = 0; n_lr = 0; ov_prev = 1'b0;
    end else begin
      chk("ready_while_busy", 32'(in_ready & busy), 32'd0);
      if (rnd_en) n_rnd++;
      if (last_round) n_lr++;
      if (round_en) begin
        n_re++;
        if (q0.size() == 0) chk("re_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("re_kind", 32'(e.ov), 32'd0);
          chk("re_cycle", 32'(cyc), 32'(e.cyc));
          chk("re_round", 32'(round), 32'(e.rnd));
          chk("re_last_round", 32'(last_round), 32'(e.rnd == 10));
          chk("re_rcon", 32'(sh_RCON), 32'(spread(rc(e.rnd))));
          if (e.rnd == 10) chk("rcon_r10", 32'(sh_RCON), 32'h0514);
        end
      end
      if (out_valid && !ov_prev) begin
        if (q0.size() == 0) chk("ov_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          chk("ov_kind", 32'(e.ov), 32'd1);
          chk("ov_cycle", 32'(cyc), 32'(e.cyc));
          chk("rnd_en_count", 32'(n_rnd), 32'd40);
          chk("round_en_count", 32'(n_re), 32'd10);
          chk("last_round_count", 32'(n_lr), 32'd4);
        end
        n_rnd = 0; n_re = 0; n_lr = 0;
      end
      ov_prev = out_valid;
    end
  end

  // Monitor for the LATENCY=1 instance
  int   m_re;
  logic ov1_prev;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_re = 0; ov1_prev = 1'b0;
    end else begin
      if (round_en1) begin
        m_re++;
        if (q1.size() == 0) chk("l1_re_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("l1_re_cycle", 32'(cyc), 32'(e.cyc));
          chk("l1_re_round", 32'(round1), 32'(e.rnd));
        end
      end
      if (out_valid1 && !ov1_prev) begin
        if (q1.size() == 0) chk("l1_ov_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("l1_ov_kind", 32'(e.ov), 32'd1);
          chk("l1_ov_cycle", 32'(cyc), 32'(e.cyc));
          chk("l1_round_en_count", 32'(m_re), 32'd10);
        end
        m_re = 0;
      end
      ov1_prev = out_valid1;
    end
  end

  task automatic req0(output int t);
    @(posedge clk); #1 in_valid = 1'b1;
    @(negedge clk);
    chk("req_in_ready", 32'(in_ready), 32'd1);
    chk("req_load", 32'(load), 32'd1);
    t = cyc;
    push_enc(t, 4, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic drain0(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q0.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_q0", 32'(q0.size()), 32'd0);
  endtask

  initial begin
    int t, tprev, found;
    // Asynchronous reset seen without any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_ctrl", 32'({load, round_en, last_round, rnd_en, out_valid, busy}), 32'd0);
    chk("rst_rcon", 32'(sh_RCON), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_round", 32'(round), 32'd0);

    // Single encryption followed by 20 cycles of backpressure
    req0(t);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    chk("ov_seen", 32'(found), 32'd1);
    @(posedge clk); #1 in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_quiet", 32'({round_en, rnd_en, load, in_ready, busy}), 32'd0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_round", 32'(round), 32'd0);
    drain0(2);

    // Reset during round 5, then a clean encryption
    req0(t);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (round == 4'd5) found = 1;
    end
    chk("reach_round5", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_round", 32'(round), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_ctrl", 32'({round_en, last_round, rnd_en, out_valid, busy}), 32'd0);
    chk("midrst_rcon", 32'(sh_RCON), 32'd0);
    q0.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    req0(t);
    drain0(60);

    // Back-to-back with in_valid and out_ready held high
    @(posedge clk); #1 in_valid = 1'b1; out_ready = 1'b1;
    tprev = 0;
    for (int n = 0; n < 3; n++) begin
      found = 0;
      for (int i = 0; i < 50 && found == 0; i++) begin
        @(negedge clk);
        if (in_valid && in_ready) found = 1;
      end
      chk("b2b_accept", 32'(found), 32'd1);
      t = cyc;
      chk("b2b_load", 32'(load), 32'd1);
      push_enc(t, 4, 1'b0);
      if (n > 0) chk("b2b_period", 32'(t - tprev), 32'd42);
      tprev = t;
    end
    @(posedge clk); #1 in_valid = 1'b0;
    drain0(60);

    // LATENCY=1 instance
    @(posedge clk); #1 in_valid1 = 1'b1;
    @(negedge clk);
    chk("l1_in_ready", 32'(in_ready1), 32'd1);
    t = cyc;
    push_enc(t, 1, 1'b1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (q1.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_q1", 32'(q1.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
